// File: rtl/stream_downsize.sv
// AXI-Stream width down-converter: one wide beat in, up to RATIO narrow beats out,
// lowest slice first, skipping slices whose keep bits are all zero.
module stream_downsize #(
    parameter int unsigned IN_BYTES   = 8,
    parameter int unsigned RATIO      = 4,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH = 1,
    parameter int unsigned USER_WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          s_t_valid,
    output logic                          s_t_ready,
    input  logic [8*IN_BYTES-1:0]         s_t_data,
    input  logic [IN_BYTES-1:0]           s_t_strb,
    input  logic [IN_BYTES-1:0]           s_t_keep,
    input  logic                          s_t_last,
    input  logic [ID_WIDTH-1:0]           s_t_id,
    input  logic [DEST_WIDTH-1:0]         s_t_dest,
    input  logic [USER_WIDTH-1:0]         s_t_user,

    output logic                          m_t_valid,
    input  logic                          m_t_ready,
    output logic [8*(IN_BYTES/RATIO)-1:0] m_t_data,
    output logic [IN_BYTES/RATIO-1:0]     m_t_strb,
    output logic [IN_BYTES/RATIO-1:0]     m_t_keep,
    output logic                          m_t_last,
    output logic [ID_WIDTH-1:0]           m_t_id,
    output logic [DEST_WIDTH-1:0]         m_t_dest,
    output logic [USER_WIDTH-1:0]         m_t_user
);

    localparam int unsigned OUT_BYTES = IN_BYTES / RATIO;
    localparam int unsigned IN_W      = 8 * IN_BYTES;
    localparam int unsigned OUT_W     = 8 * OUT_BYTES;

    if (RATIO < 2 || (IN_BYTES % RATIO) != 0) begin : g_param_check
        $fatal(1, "stream_downsize: IN_BYTES must be divisible by RATIO, and RATIO >= 2");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [RATIO-1:0]       pend_q, pend_d;
    logic [IN_W-1:0]        data_q;
    logic [IN_BYTES-1:0]    strb_q;
    logic [IN_BYTES-1:0]    keep_q;
    logic                   last_q;
    logic [ID_WIDTH-1:0]    id_q;
    logic [DEST_WIDTH-1:0]  dest_q;
    logic [USER_WIDTH-1:0]  user_q;

    logic [RATIO-1:0]       keep_pend_c;
    logic [RATIO-1:0]       load_pend_c;
    logic [RATIO-1:0]       cur_oh_c;
    logic                   final_slice_c;
    logic                   load_c;

    // Pending mask for an incoming beat; a fully null last beat still yields one slice
    always_comb begin
        keep_pend_c = '0;
        for (int i = 0; i < RATIO; i++) begin
            keep_pend_c[i] = |s_t_keep[i*OUT_BYTES +: OUT_BYTES];
        end
        load_pend_c = keep_pend_c;
        if (keep_pend_c == '0 && s_t_last) begin
            load_pend_c = RATIO'(1);
        end
    end

    // Current slice is the lowest pending bit
    always_comb begin
        cur_oh_c      = pend_q & ~(pend_q - RATIO'(1));
        final_slice_c = (pend_q & ~cur_oh_c) == '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            pend_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            id_q    <= '0;
            dest_q  <= '0;
            user_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (load_c) begin
                data_q <= s_t_data;
                strb_q <= s_t_strb;
                keep_q <= s_t_keep;
                last_q <= s_t_last;
                id_q   <= s_t_id;
                dest_q <= s_t_dest;
                user_q <= s_t_user;
            end
        end
    end

    // Next state and handshakes; a final-slice handshake may reload in the same cycle
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        load_c    = 1'b0;
        s_t_ready = 1'b0;
        m_t_valid = 1'b0;

        case (state_q)
            EMPTY: begin
                s_t_ready = 1'b1;
                load_c    = s_t_valid;
            end
            HOLD: begin
                m_t_valid = 1'b1;
                if (m_t_ready) begin
                    pend_d = pend_q & ~cur_oh_c;
                    if (final_slice_c) begin
                        s_t_ready = 1'b1;
                        state_d   = EMPTY;
                        load_c    = s_t_valid;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase

        if (load_c) begin
            pend_d  = load_pend_c;
            state_d = (load_pend_c != '0) ? HOLD : EMPTY;
        end

        if (rst) begin
            s_t_ready = 1'b0;
            m_t_valid = 1'b0;
            load_c    = 1'b0;
        end
    end

    // Narrow slice mux; outputs are zero whenever nothing is offered
    always_comb begin
        m_t_data = '0;
        m_t_strb = '0;
        m_t_keep = '0;
        m_t_last = 1'b0;
        m_t_id   = '0;
        m_t_dest = '0;
        m_t_user = '0;
        if (m_t_valid) begin
            for (int i = 0; i < RATIO; i++) begin
                if (cur_oh_c[i]) begin
                    m_t_data = data_q[i*OUT_W +: OUT_W];
                    m_t_strb = strb_q[i*OUT_BYTES +: OUT_BYTES];
                    m_t_keep = keep_q[i*OUT_BYTES +: OUT_BYTES];
                end
            end
            m_t_last = last_q && final_slice_c;
            m_t_id   = id_q;
            m_t_dest = dest_q;
            m_t_user = user_q;
        end
    end

endmodule

// File: tb/tb_stream_downsize.sv
// Self-checking bench for stream_downsize (IN_BYTES=8, RATIO=4) with a queue-based
// reference model that expands each accepted wide beat into its expected narrow beats.
module tb_stream_downsize;

    localparam int unsigned IN_BYTES = 8;
    localparam int unsigned RATIO    = 4;
    localparam int unsigned IDW      = 2;
    localparam int unsigned DSW      = 3;
    localparam int unsigned USW      = 4;
    localparam int unsigned NBP      = 1000;

    typedef struct packed {
        logic [15:0]    data;
        logic [1:0]     strb;
        logic [1:0]     keep;
        logic           last;
        logic [IDW-1:0] id;
        logic [DSW-1:0] dest;
        logic [USW-1:0] user;
    } nb_t;

    logic           clk;
    logic           rst;
    logic           s_t_valid;
    logic           s_t_ready;
    logic [63:0]    s_t_data;
    logic [7:0]     s_t_strb;
    logic [7:0]     s_t_keep;
    logic           s_t_last;
    logic [IDW-1:0] s_t_id;
    logic [DSW-1:0] s_t_dest;
    logic [USW-1:0] s_t_user;
    logic           m_t_valid;
    logic           m_t_ready;
    logic [15:0]    m_t_data;
    logic [1:0]     m_t_strb;
    logic [1:0]     m_t_keep;
    logic           m_t_last;
    logic [IDW-1:0] m_t_id;
    logic [DSW-1:0] m_t_dest;
    logic [USW-1:0] m_t_user;

    int  checks = 0;
    int  errors = 0;
    nb_t exp_q[$];

    stream_downsize #(
        .IN_BYTES  (IN_BYTES),
        .RATIO     (RATIO),
        .ID_WIDTH  (IDW),
        .DEST_WIDTH(DSW),
        .USER_WIDTH(USW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_t_valid(s_t_valid),
        .s_t_ready(s_t_ready),
        .s_t_data (s_t_data),
        .s_t_strb (s_t_strb),
        .s_t_keep (s_t_keep),
        .s_t_last (s_t_last),
        .s_t_id   (s_t_id),
        .s_t_dest (s_t_dest),
        .s_t_user (s_t_user),
        .m_t_valid(m_t_valid),
        .m_t_ready(m_t_ready),
        .m_t_data (m_t_data),
        .m_t_strb (m_t_strb),
        .m_t_keep (m_t_keep),
        .m_t_last (m_t_last),
        .m_t_id   (m_t_id),
        .m_t_dest (m_t_dest),
        .m_t_user (m_t_user)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic nb_t observed();
        nb_t o;
        o.data = m_t_data;
        o.strb = m_t_strb;
        o.keep = m_t_keep;
        o.last = m_t_last;
        o.id   = m_t_id;
        o.dest = m_t_dest;
        o.user = m_t_user;
        return o;
    endfunction

    // Reference model: each 2-byte slice with any keep bit becomes one narrow beat;
    // last marks the highest such slice; an all-null last beat becomes one null beat.
    function automatic void expand(input logic [63:0] d, input logic [7:0] s,
                                   input logic [7:0] k, input logic l,
                                   input logic [IDW-1:0] id, input logic [DSW-1:0] dest,
                                   input logic [USW-1:0] user);
        int  top = -1;
        nb_t e;
        for (int i = 0; i < 4; i++) if (k[2*i +: 2] != 2'b00) top = i;
        if (top < 0) begin
            if (l) begin
                e = '{data: d[15:0], strb: s[1:0], keep: 2'b00, last: 1'b1,
                      id: id, dest: dest, user: user};
                exp_q.push_back(e);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (k[2*i +: 2] != 2'b00) begin
                    e = '{data: d[16*i +: 16], strb: s[2*i +: 2], keep: k[2*i +: 2],
                          last: l && (i == top), id: id, dest: dest, user: user};
                    exp_q.push_back(e);
                end
            end
        end
    endfunction

    task automatic drive_idle();
        s_t_valid = 1'b0;
        s_t_data  = '0;
        s_t_strb  = '0;
        s_t_keep  = '0;
        s_t_last  = 1'b0;
        s_t_id    = '0;
        s_t_dest  = '0;
        s_t_user  = '0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        m_t_ready = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_t_ready !== 1'b0 || m_t_valid !== 1'b0)
            $display("FAIL reset_handshake: got s_ready=%b m_valid=%b, required 0 0", s_t_ready, m_t_valid);
        checks++;
        if (observed() !== nb_t'(0))
            $display("FAIL reset_outputs: got %h, required 0", observed());
        if (observed() !== nb_t'(0)) errors++;
        if (s_t_ready !== 1'b0 || m_t_valid !== 1'b0) errors++;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_t_ready !== 1'b1 || m_t_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got s_ready=%b m_valid=%b, required 1 0", s_t_ready, m_t_valid);
        end
    endtask

    task automatic test_full_beat();
        logic [63:0] w = 64'h8877665544332211;
        @(posedge clk);
        #1;
        s_t_valid = 1'b1; s_t_data = w; s_t_strb = 8'hFF; s_t_keep = 8'hFF; s_t_last = 1'b1;
        m_t_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (s_t_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_accept: got s_ready=%b, required 1", s_t_ready);
        end
        @(posedge clk);
        #1 drive_idle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (m_t_valid !== 1'b1 || m_t_data !== w[16*k +: 16] || m_t_keep !== 2'b11 ||
                m_t_last !== (k == 3)) begin
                errors++;
                $display("FAIL full_slice%0d: got v=%b d=%h k=%b l=%b, required 1 %h 11 %b",
                         k, m_t_valid, m_t_data, m_t_keep, m_t_last, w[16*k +: 16], k == 3);
            end
            if (k == 3) begin
                checks++;
                if (s_t_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL full_ready4: got s_ready=%b, required 1", s_t_ready);
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (m_t_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_idle: got m_valid=%b, required 0", m_t_valid);
        end
    endtask

    task automatic test_sparse();
        logic [15:0] ed[2] = '{16'h2211, 16'h8877};
        @(posedge clk);
        #1;
        s_t_valid = 1'b1; s_t_data = 64'h8877665544332211; s_t_strb = 8'hC3; s_t_keep = 8'hC3;
        s_t_last = 1'b0; m_t_ready = 1'b1;
        @(posedge clk);
        #1 drive_idle();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (m_t_valid !== 1'b1 || m_t_data !== ed[k] || m_t_keep !== 2'b11 || m_t_last !== 1'b0) begin
                errors++;
                $display("FAIL sparse_slice%0d: got v=%b d=%h k=%b l=%b, required 1 %h 11 0",
                         k, m_t_valid, m_t_data, m_t_keep, m_t_last, ed[k]);
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (m_t_valid !== 1'b0) begin
            errors++;
            $display("FAIL sparse_count: got m_valid=%b after two beats, required 0", m_t_valid);
        end
    endtask

    task automatic test_null();
        @(posedge clk);
        #1;
        s_t_valid = 1'b1; s_t_data = 64'h1234; s_t_keep = 8'h00; s_t_last = 1'b0; m_t_ready = 1'b1;
        @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        checks++;
        if (m_t_valid !== 1'b0 || s_t_ready !== 1'b1) begin
            errors++;
            $display("FAIL null_drop: got m_valid=%b s_ready=%b, required 0 1", m_t_valid, s_t_ready);
        end
        @(posedge clk);
        #1;
        s_t_valid = 1'b1; s_t_keep = 8'h00; s_t_last = 1'b1;
        @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        checks++;
        if (m_t_valid !== 1'b1 || m_t_keep !== 2'b00 || m_t_last !== 1'b1) begin
            errors++;
            $display("FAIL null_last: got v=%b k=%b l=%b, required 1 00 1", m_t_valid, m_t_keep, m_t_last);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_t_valid !== 1'b0) begin
            errors++;
            $display("FAIL null_single: got m_valid=%b, required 0", m_t_valid);
        end
    endtask

    task automatic test_backpressure();
        int  sent = 0;
        int  cyc = 0;
        bit  have = 0;
        bit  prev_stall = 0;
        nb_t prev_obs = '0;
        nb_t e;
        int  stab_err = 0;
        int  data_err = 0;
        exp_q.delete();
        while ((sent < NBP || exp_q.size() != 0 || have) && cyc < 30000) begin
            @(posedge clk);
            #1;
            if (!have && sent < NBP && ($urandom % 4) != 0) begin
                have = 1;
                s_t_data = {$urandom, $urandom};
                s_t_strb = 8'($urandom);
                case ($urandom % 4)
                    0:       s_t_keep = 8'hFF;
                    1:       s_t_keep = 8'h00;
                    default: s_t_keep = 8'($urandom);
                endcase
                s_t_last = ($urandom % 3) == 0;
                s_t_id   = IDW'($urandom);
                s_t_dest = DSW'($urandom);
                s_t_user = USW'($urandom);
            end
            s_t_valid = have;
            m_t_ready = ($urandom % 2) == 1;
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                checks++;
                if (m_t_valid !== 1'b1 || observed() !== prev_obs) begin
                    errors++;
                    stab_err++;
                    if (stab_err < 5)
                        $display("FAIL bp_stable: got v=%b %h, required 1 %h", m_t_valid, observed(), prev_obs);
                end
            end
            prev_stall = m_t_valid && !m_t_ready;
            prev_obs   = observed();
            if (m_t_valid && m_t_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    data_err++;
                    if (data_err < 5) $display("FAIL bp_extra: got beat %h, required none", observed());
                end else begin
                    e = exp_q.pop_front();
                    if (observed() !== e) begin
                        errors++;
                        data_err++;
                        if (data_err < 5) $display("FAIL bp_beat: got %h, required %h", observed(), e);
                    end
                end
            end
            if (s_t_valid && s_t_ready) begin
                expand(s_t_data, s_t_strb, s_t_keep, s_t_last, s_t_id, s_t_dest, s_t_user);
                have = 0;
                sent++;
            end
        end
        @(posedge clk);
        #1 drive_idle();
        m_t_ready = 1'b1;
        checks++;
        if (sent != NBP || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got sent=%0d pending=%0d, required %0d 0", sent, exp_q.size(), NBP);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0]    bd[16];
        logic [IDW-1:0] bid[16];
        int  b = 0;
        int  hs = 0;
        int  first = -1;
        int  lastc = -1;
        int  err_local = 0;
        nb_t e;
        for (int i = 0; i < 16; i++) begin
            bd[i]  = {$urandom, $urandom};
            bid[i] = IDW'($urandom);
        end
        exp_q.delete();
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(posedge clk);
            #1;
            m_t_ready = 1'b1;
            if (b < 16) begin
                s_t_valid = 1'b1; s_t_data = bd[b]; s_t_strb = 8'hFF; s_t_keep = 8'hFF;
                s_t_last = (b % 4) == 3; s_t_id = bid[b]; s_t_dest = DSW'(b); s_t_user = USW'(b);
            end else begin
                drive_idle();
            end
            @(negedge clk);
            if (m_t_valid && m_t_ready) begin
                hs++;
                if (first < 0) first = cyc;
                lastc = cyc;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : nb_t'(0);
                if (observed() !== e) err_local++;
            end
            if (s_t_valid && s_t_ready) begin
                expand(s_t_data, s_t_strb, s_t_keep, s_t_last, s_t_id, s_t_dest, s_t_user);
                b++;
            end
        end
        checks++;
        if (hs != 64 || lastc - first + 1 != 64) begin
            errors++;
            $display("FAIL b2b_rate: got %0d handshakes over %0d cycles, required 64 over 64",
                     hs, lastc - first + 1);
        end
        checks++;
        if (err_local != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_data: got %0d wrong beats %0d missing, required 0 0", err_local, exp_q.size());
        end

        b = 0;
        err_local = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(posedge clk);
            #1;
            rst = (cyc == 30);
            if (b < 16 && cyc < 30) begin
                s_t_valid = 1'b1; s_t_data = bd[b]; s_t_strb = 8'hFF; s_t_keep = 8'hFF;
                s_t_last = 1'b0; s_t_id = bid[b]; s_t_dest = '0; s_t_user = '0;
            end else begin
                drive_idle();
            end
            @(negedge clk);
            if (cyc == 30) begin
                exp_q.delete();
                checks++;
                if (m_t_valid !== 1'b0 || s_t_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_rst: got m_valid=%b s_ready=%b, required 0 0", m_t_valid, s_t_ready);
                end
            end else if (cyc > 30) begin
                if (m_t_valid !== 1'b0) err_local++;
            end else if (m_t_valid && m_t_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : nb_t'(0);
                if (observed() !== e) err_local++;
            end
            if (s_t_valid && s_t_ready) begin
                expand(s_t_data, s_t_strb, s_t_keep, s_t_last, s_t_id, s_t_dest, s_t_user);
                b++;
            end
        end
        checks++;
        if (err_local != 0) begin
            errors++;
            $display("FAIL b2b_stale: got %0d bad cycles around reset, required 0", err_local);
        end
    endtask

    initial begin
        test_reset();
        test_full_beat();
        test_sparse();
        test_null();
        test_backpressure();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_downsize.md
# stream_downsize

Width down-converter for AXI-Stream channels. It accepts one wide beat and emits it as RATIO narrow beats, lowest bytes first, at one narrow beat per cycle. Narrow slices whose t_keep bits are all zero are skipped. It sits directly upstream of a stream_buf on the narrow side, for example when feeding a narrow peripheral from a wide DMA path, and is used at the same clock as that buffer.

## Interface
- IN_BYTES, 8: wide data width in bytes; must be divisible by RATIO, else elaboration fails with $fatal.
- RATIO, 4: down-conversion ratio, at least 2; narrow width OUT_BYTES = IN_BYTES/RATIO.
- ID_WIDTH, 1; DEST_WIDTH, 1; USER_WIDTH, 1: sideband widths, identical on both sides.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_t_valid / s_t_ready  in / out  1  wide-side handshake.
- s_t_data  in  8·IN_BYTES; s_t_strb, s_t_keep  in  IN_BYTES; s_t_last  in  1; s_t_id, s_t_dest, s_t_user  in  sideband widths.
- m_t_valid / m_t_ready  out / in  1  narrow-side handshake.
- m_t_data  out  8·OUT_BYTES; m_t_strb, m_t_keep  out  OUT_BYTES; m_t_last  out  1; m_t_id, m_t_dest, m_t_user  out  sideband widths.

## Operation
- Holding register stores one wide beat: data, strb, keep, last, id, dest, user. It also stores a pending-slice mask P[RATIO-1:0].
  - P[i] = 1 for each slice i whose keep is non-zero.
- Two states:
  - EMPTY: s_t_ready = 1, m_t_valid = 0.
  - HOLD: m_t_valid = 1; the current slice index is the lowest i with P[i] = 1.
- Load, on s_t_valid && s_t_ready:
  - P non-zero: go to HOLD.
  - P all zero and s_t_last = 1: set P = 1 (slice 0 only) and go to HOLD. The result is a single null narrow beat with keep = 0 and last = 1.
  - P all zero and s_t_last = 0: drop the beat and stay in (or return to) EMPTY.
- Output in HOLD:
  - m_t_data, m_t_strb and m_t_keep carry the current slice (bytes i·OUT_BYTES upward).
  - m_t_id, m_t_dest and m_t_user are copied from the held beat for every slice.
  - m_t_last = held last AND the current slice is the only bit set in P.
- On m_t_valid && m_t_ready: clear the current P bit.
  - If it was the final slice and s_t_valid = 1: load the new beat in the same cycle. This is full throughput with no bubble.
  - If it was the final slice and s_t_valid = 0: go to EMPTY.
- s_t_ready = EMPTY OR (HOLD AND m_t_ready AND current slice is final). This combinational path from m_t_ready to s_t_ready is permitted.
- Output stability: while m_t_valid && !m_t_ready, every m_* output holds stable. m_t_valid never deasserts without a handshake.
- Strb bytes outside keep are passed through unchanged; no check is performed on them.

## Timing
- Reset: while rst = 1, m_t_valid = 0, s_t_ready = 0, all m_* data and sideband outputs = 0, P = 0, state = EMPTY.
  - s_t_ready = 1 in the first cycle after rst falls.
- Reset mid-packet discards the held beat and all pending slices; there is no partial output afterwards.
- Latency: a wide beat accepted at edge N presents its first narrow slice from cycle N+1.
- Throughput with m_t_ready held high and all keep set: RATIO output beats per input beat, with no idle cycles between consecutive wide beats.
- Slices with keep = 0 cost zero cycles.
- A wide beat with K non-null slices occupies exactly K output handshakes.

## Test plan
- Reset, IN_BYTES = 8, RATIO = 4:
  - During rst, s_t_ready = 0 and m_t_valid = 0; the cycle after, s_t_ready = 1.
- Full beat, data 0x8877665544332211, keep 0xFF, last 1, m_t_ready = 1:
  - Output data 0x2211, 0x4433, 0x6655, 0x8877 on four consecutive cycles.
  - m_t_last = 1 only on 0x8877.
  - s_t_ready is high in the fourth cycle.
- Sparse keep 0xC3, last 0:
  - Exactly two output beats, 0x2211 (keep 0x3) and 0x8877 (keep 0x3), with last = 0 on both.
- Null beats:
  - keep 0x00, last 0: no output, and s_t_ready stays high.
  - keep 0x00, last 1: one output beat with keep 0x0 and last 1.
- Backpressure: m_t_ready toggled with a pseudo-random pattern over 1000 wide beats.
  - m_* outputs are stable whenever valid && !ready.
  - The output byte stream equals the input keep-selected bytes.
  - id, dest and user match their source beat.
- Back-to-back, s_t_valid and m_t_ready held high, 16 beats with keep 0xFF:
  - Exactly 64 output handshakes in 64 consecutive cycles.
  - rst asserted in cycle 30: m_t_valid = 0 the next cycle, and no stale slices appear after reset.
